comp_serial_nbit: RTL and testbench
===================================

# comp_serial_nbit

Multi-cycle, bit-serial N-bit magnitude comparator. It captures two unsigned operands on a start pulse and walks them MSB-first, one 1-bit compare per clock. It reports exactly one of less/greater/equal, together with a one-cycle done pulse. It extends the 1-bit comparator to wide operands by iterating a single compare slice over time rather than replicating it, and serves as the area-lean compare unit for datapaths that can tolerate multi-cycle latency.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..32.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only when busy=0.
- a  input  WIDTH  operand A, unsigned; sampled on the accepted start.
- b  input  WIDTH  operand B, unsigned; sampled on the accepted start.
- busy  output  1  high while a compare is in progress.
- done  output  1  one-cycle pulse; l/g/e are valid from this cycle on.
- l  output  1  A < B.
- g  output  1  A > B.
- e  output  1  A == B.

## Operation
- States:
  - IDLE: waits for start.
  - RUN: steps through the bits.
- IDLE, start=1:
  - Load a and b into shift registers sa/sb.
  - Set bit counter cnt = WIDTH-1.
  - Clear l/g/e to 0 and set busy=1.
  - Go to RUN.
- RUN, each cycle: compare sa[WIDTH-1] with sb[WIDTH-1], then shift both left by 1 and decrement cnt.
  - Bits differ: latch g = sa_msb & ~sb_msb and l = ~sa_msb & sb_msb into sticky flags; later bits never change them.
  - Final step (cnt==0) with no difference seen: set e=1.
- Completion:
  - Registered done=1 for exactly one cycle.
  - busy=0 and state returns to IDLE on the same edge.
  - l/g/e hold their value until the next accepted start.
- At most one of l/g/e is high at any time. All three are 0 while busy and after reset.
- start while busy=1 is ignored; operand registers are unaffected.
- a/b are don't-care except on the accepted start edge.

## Timing
- Reset values: busy=0, done=0, l=0, g=0, e=0, state IDLE.
- Reset asserted mid-RUN aborts immediately to these values. No done is produced for the aborted operation.
- start is accepted at edge T0 (busy rises after T0).
- Latency: done is high in the cycle after edge T0+n, where n is the number of RUN cycles.
  - With early exit: n = k+1, where k is the MSB-first index of the first differing bit (MSB differs → n=1). Equal operands → n=WIDTH.
  - Without early exit: n = WIDTH always.
- Back-to-back: start asserted during the done cycle is accepted, since busy is already 0. Throughput is one compare per n+1 cycles minimum.
- No combinational path from inputs to outputs; all outputs are registered.

## Configuration
- COMP_EARLY_EXIT_EN:
  - Defined: RUN terminates on the cycle the first differing bit is found, so data-dependent latency is 1..WIDTH.
  - Undefined: RUN always executes WIDTH cycles (constant latency, for schedule-locked datapaths). The flags are still set on the first difference and held sticky until completion.
  - Results are identical either way.

## Test plan
- WIDTH=8, a=8'hA5, b=8'hA5, start → e=1, l=g=0, done exactly 8 cycles after acceptance, in both configurations.
- a=8'h80, b=8'h7F → g=1. done after 1 cycle with COMP_EARLY_EXIT_EN, after 8 cycles without.
- a=8'h12, b=8'h13 (LSB-only difference) → l=1, done after 8 cycles in both configurations.
- Start a=8'h01, b=8'hFF; while busy, pulse start with a=8'hFF, b=8'h00 → the second start is ignored and the result is l=1 with exactly one done pulse.
- Assert rst_n=0 in the middle of a compare → busy/done/l/g/e all 0 asynchronously, no done after release. A fresh start a=8'h40, b=8'h3F then yields g=1.
- Start a=8'h10, b=8'h20, then assert start on the done cycle with a=8'h30, b=8'h30 → first result l=1, second accepted immediately, ending with e=1. l clears to 0 on the second acceptance.

Source files
------------

// File: rtl/comp_serial_nbit.sv
// -----------------------------------------------------------------------------
// comp_serial_nbit
//
// Bit-serial N-bit unsigned magnitude comparator. Operands are captured on an
// accepted start and walked MSB-first, one 1-bit compare per clock. When the
// walk finishes, exactly one of l/g/e is set and done pulses for one cycle.
//
// Parameters:
//   WIDTH  operand width in bits (2..32)
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   compare request, only sampled while busy=0
//   a, b   in   unsigned operands, sampled on the accepted start edge
//   busy   out  high while a compare is in progress
//   done   out  one-cycle pulse; l/g/e are valid from this cycle on
//   l      out  a < b
//   g      out  a > b
//   e      out  a == b
//
// Configuration macro:
//   COMP_EARLY_EXIT_EN  defined: RUN ends on the first differing bit
//                       (latency 1..WIDTH). Undefined: RUN always takes
//                       WIDTH cycles. The result is the same either way.
// -----------------------------------------------------------------------------
module comp_serial_nbit #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             l,
  output logic             g,
  output logic             e
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  // Internal sticky flags: record the first difference while walking. The
  // visible l/g/e stay 0 while busy and are only loaded at completion.
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             l_q, l_d;
  logic             g_q, g_d;
  logic             e_q, e_d;

  logic             msb_a;
  logic             msb_b;
  logic             finish;

  assign msb_a = sa_q[WIDTH-1];
  assign msb_b = sb_q[WIDTH-1];

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    lt_d    = lt_q;
    gt_d    = gt_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    l_d     = l_q;
    g_d     = g_q;
    e_d     = e_q;
    finish  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(WIDTH - 1);
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          l_d     = 1'b0;
          g_d     = 1'b0;
          e_d     = 1'b0;
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end

      RUN: begin
        sa_d  = {sa_q[WIDTH-2:0], 1'b0};
        sb_d  = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;

        // Only the first differing bit decides; later bits are ignored.
        if (!(lt_q || gt_q)) begin
          lt_d = ~msb_a & msb_b;
          gt_d = msb_a & ~msb_b;
        end

`ifdef COMP_EARLY_EXIT_EN
        finish = (cnt_q == '0) || (msb_a ^ msb_b);
`else
        finish = (cnt_q == '0);
`endif

        if (finish) begin
          l_d     = lt_d;
          g_d     = gt_d;
          e_d     = ~(lt_d | gt_d);
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      l_q     <= 1'b0;
      g_q     <= 1'b0;
      e_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      l_q     <= l_d;
      g_q     <= g_d;
      e_q     <= e_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign l    = l_q;
  assign g    = g_q;
  assign e    = e_q;

endmodule

// File: tb/tb_comp_serial_nbit.sv
// -----------------------------------------------------------------------------
// tb_comp_serial_nbit
//
// Directed bench for comp_serial_nbit (WIDTH=8). Expected results and
// latencies are hand-computed per vector; latency expectations follow
// COMP_EARLY_EXIT_EN when the bench is built with the same macro.
// -----------------------------------------------------------------------------
module tb_comp_serial_nbit;

  localparam int WIDTH = 8;
`ifdef COMP_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             l;
  logic             g;
  logic             e;

  int checks = 0;
  int errors = 0;

  comp_serial_nbit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .l     (l),
    .g     (g),
    .e     (e)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present operands with start=1, let the acceptance edge pass, drop start.
  task automatic do_start(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges after acceptance until done is seen (returns 0 on timeout).
  task automatic wait_done(output int n);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic el, input logic eg, input logic ee, input int en);
    int n;
    do_start(av, bv);
    check({tag, " busy"}, busy, 1'b1);
    check({tag, " lge_busy"}, {l, g, e}, 3'b000);
    wait_done(n);
    check({tag, " latency"}, n, en);
    check({tag, " lge"}, {l, g, e}, {el, eg, ee});
    check({tag, " busy_done"}, busy, 1'b0);
  endtask

  initial begin
    int n;
    int dcount;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #1;
    check("reset", {busy, done, l, g, e}, 5'b00000);
    #12;
    rst_n = 1'b1;
    @(negedge clk);

    // Equal operands: full walk in both configurations.
    run_cmp("eq_A5", 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b1, 8);
    @(posedge clk); #1;
    check("done_one_cycle", done, 1'b0);
    check("hold_lge", {l, g, e}, 3'b001);

    // MSB differs.
    run_cmp("gt_80_7F", 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0, EE ? 1 : 8);
    // LSB-only difference.
    run_cmp("lt_12_13", 8'h12, 8'h13, 1'b1, 1'b0, 1'b0, 8);
    run_cmp("gt_FF_FE", 8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0, 8);
    run_cmp("lt_00_FF", 8'h00, 8'hFF, 1'b1, 1'b0, 1'b0, EE ? 1 : 8);
    run_cmp("eq_00", 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 8);

    // Start while busy is ignored: keep start high with new operands
    // across the first RUN edge.
    a     = 8'h01;
    b     = 8'hFF;
    start = 1'b1;
    @(posedge clk); #1;
    a = 8'hFF;
    b = 8'h00;
    @(posedge clk); #1;
    start  = 1'b0;
    dcount = done ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("ignore_done_count", dcount, 1);
    check("ignore_lge", {l, g, e}, 3'b100);
    check("ignore_idle", busy, 1'b0);

    // Asynchronous reset in the middle of a compare.
    @(negedge clk);
    do_start(8'hA5, 8'hA5);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midreset_outs", {busy, done, l, g, e}, 5'b00000);
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("midreset_no_done", dcount, 0);
    check("midreset_idle", busy, 1'b0);
    run_cmp("gt_40_3F", 8'h40, 8'h3F, 1'b0, 1'b1, 1'b0, EE ? 2 : 8);

    // Back-to-back: second start issued during the done cycle.
    @(negedge clk);
    do_start(8'h10, 8'h20);
    wait_done(n);
    check("b2b_first_latency", n, EE ? 3 : 8);
    check("b2b_first_lge", {l, g, e}, 3'b100);
    a     = 8'h30;
    b     = 8'h30;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accepted", busy, 1'b1);
    check("b2b_l_cleared", {l, g, e}, 3'b000);
    wait_done(n);
    check("b2b_second_latency", n, 8);
    check("b2b_second_lge", {l, g, e}, 3'b001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
